biquad_mac_seq: RTL and testbench

- Sequencer and accumulator for one direct-form-I biquad section.
- Converts signed samples and coefficients to magnitudes and issues five operand pairs to the downstream multa pipeline.
- Tracks each product's sign through a delay line matched to the multiplier latency, then accumulates the returned products.
- Scales and saturates the result, updates the x/y history and presents y with a valid strobe.

---
 rtl/biquad_mac_seq.sv | 223 ++++++++++++++++++++++
 tb/tb_biquad_mac_seq.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/biquad_mac_seq.sv
// Direct-form-I biquad sequencer/accumulator that feeds an external unsigned multiplier pipeline.
// Define BIQUAD_ROUND_EN to round half up before saturation; otherwise the output is a floor shift.
module biquad_mac_seq #(
    parameter int MULT_LAT = 5,
    parameter int ACC_W    = 26,
    parameter int SHIFT    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [13:0] x_in,
    input  logic [9:0]  coef_b0,
    input  logic [9:0]  coef_b1,
    input  logic [9:0]  coef_b2,
    input  logic [9:0]  coef_a1,
    input  logic [9:0]  coef_a2,
    output logic        mult_en,
    output logic [8:0]  mult_a,
    output logic [12:0] mult_b,
    input  logic [21:0] mult_p,
    output logic [13:0] y_out,
    output logic        y_valid
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Only the oldest term is still in flight: that product is the last one to accumulate.
    localparam logic [MULT_LAT-1:0] LAST_TERM = {1'b1, {(MULT_LAT-1){1'b0}}};

    function automatic logic [8:0] coef_mag(input logic [9:0] c);
        logic [9:0] neg;
        neg = ~c + 10'd1;
        if (c == 10'b10_0000_0000) begin
            coef_mag = 9'd511;
        end else if (c[9]) begin
            coef_mag = neg[8:0];
        end else begin
            coef_mag = c[8:0];
        end
    endfunction

    function automatic logic [12:0] samp_mag(input logic [13:0] s);
        logic [13:0] neg;
        neg = ~s + 14'd1;
        if (s == 14'b10_0000_0000_0000) begin
            samp_mag = 13'd8191;
        end else if (s[13]) begin
            samp_mag = neg[12:0];
        end else begin
            samp_mag = s[12:0];
        end
    endfunction

    state_t                state_r;
    logic [2:0]            k_r;
    logic [9:0]            b0_r, b1_r, b2_r, a1_r, a2_r;
    logic [13:0]           x_r, x1_r, x2_r, y1_r, y2_r;
    logic [ACC_W-1:0]      acc_r;
    logic                  iss_vld_r, iss_sgn_r;
    logic [MULT_LAT-1:0]   line_vld_r, line_sgn_r;

    logic [9:0]            sel_coef_s;
    logic [13:0]           sel_samp_s;
    logic                  sel_fb_s;
    logic                  iss_sgn_s;
    logic [ACC_W-1:0]      p_ext_s, acc_sum_s;
    logic signed [ACC_W:0] acc_rnd_s, shr_s;
    logic [ACC_W-13:0]     hi_s;
    logic [13:0]           y_sat_s;

    // Operand pair for the next issue slot; the first pair comes straight from the inputs at accept.
    always_comb begin
        sel_coef_s = 10'd0;
        sel_samp_s = 14'd0;
        sel_fb_s   = 1'b0;
        if (state_r == ST_IDLE) begin
            sel_coef_s = coef_b0;
            sel_samp_s = x_in;
        end else begin
            case (k_r)
                3'd0: begin sel_coef_s = b0_r; sel_samp_s = x_r;  end
                3'd1: begin sel_coef_s = b1_r; sel_samp_s = x1_r; end
                3'd2: begin sel_coef_s = b2_r; sel_samp_s = x2_r; end
                3'd3: begin sel_coef_s = a1_r; sel_samp_s = y1_r; sel_fb_s = 1'b1; end
                3'd4: begin sel_coef_s = a2_r; sel_samp_s = y2_r; sel_fb_s = 1'b1; end
                default: begin sel_coef_s = 10'd0; sel_samp_s = 14'd0; sel_fb_s = 1'b0; end
            endcase
        end
        iss_sgn_s = sel_coef_s[9] ^ sel_samp_s[13] ^ sel_fb_s;
    end

    // Signed accumulate of the returning product, then scale and saturate to 14 bits.
    always_comb begin
        p_ext_s = {{(ACC_W-22){1'b0}}, mult_p};
        if (line_sgn_r[MULT_LAT-1]) begin
            acc_sum_s = acc_r - p_ext_s;
        end else begin
            acc_sum_s = acc_r + p_ext_s;
        end
`ifdef BIQUAD_ROUND_EN
        acc_rnd_s = {acc_sum_s[ACC_W-1], acc_sum_s} + ({{ACC_W{1'b0}}, 1'b1} << (SHIFT-1));
`else
        acc_rnd_s = {acc_sum_s[ACC_W-1], acc_sum_s};
`endif
        shr_s = acc_rnd_s >>> SHIFT;
        hi_s  = shr_s[ACC_W:13];
        if ((&hi_s) || !(|hi_s)) begin
            y_sat_s = shr_s[13:0];
        end else if (shr_s[ACC_W]) begin
            y_sat_s = 14'h2000;
        end else begin
            y_sat_s = 14'h1FFF;
        end
    end

    // Sequencer FSM, sign/valid delay line, accumulator and history registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            in_ready   <= 1'b1;
            k_r        <= 3'd0;
            b0_r       <= 10'd0;
            b1_r       <= 10'd0;
            b2_r       <= 10'd0;
            a1_r       <= 10'd0;
            a2_r       <= 10'd0;
            x_r        <= 14'd0;
            x1_r       <= 14'd0;
            x2_r       <= 14'd0;
            y1_r       <= 14'd0;
            y2_r       <= 14'd0;
            acc_r      <= {ACC_W{1'b0}};
            iss_vld_r  <= 1'b0;
            iss_sgn_r  <= 1'b0;
            line_vld_r <= {MULT_LAT{1'b0}};
            line_sgn_r <= {MULT_LAT{1'b0}};
            mult_en    <= 1'b0;
            mult_a     <= 9'd0;
            mult_b     <= 13'd0;
            y_out      <= 14'd0;
            y_valid    <= 1'b0;
        end else begin
            line_vld_r <= {line_vld_r[MULT_LAT-2:0], iss_vld_r};
            line_sgn_r <= {line_sgn_r[MULT_LAT-2:0], iss_sgn_r};
            if (line_vld_r[MULT_LAT-1]) begin
                acc_r <= acc_sum_s;
            end
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        b0_r      <= coef_b0;
                        b1_r      <= coef_b1;
                        b2_r      <= coef_b2;
                        a1_r      <= coef_a1;
                        a2_r      <= coef_a2;
                        x_r       <= x_in;
                        acc_r     <= {ACC_W{1'b0}};
                        mult_en   <= 1'b1;
                        mult_a    <= coef_mag(sel_coef_s);
                        mult_b    <= samp_mag(sel_samp_s);
                        iss_vld_r <= 1'b1;
                        iss_sgn_r <= iss_sgn_s;
                        k_r       <= 3'd1;
                        in_ready  <= 1'b0;
                        state_r   <= ST_ISSUE;
                    end else begin
                        iss_vld_r <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    if (k_r <= 3'd4) begin
                        mult_a    <= coef_mag(sel_coef_s);
                        mult_b    <= samp_mag(sel_samp_s);
                        iss_vld_r <= 1'b1;
                        iss_sgn_r <= iss_sgn_s;
                        k_r       <= k_r + 3'd1;
                    end else begin
                        mult_a    <= 9'd0;
                        mult_b    <= 13'd0;
                        iss_vld_r <= 1'b0;
                        iss_sgn_r <= 1'b0;
                        state_r   <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (line_vld_r == LAST_TERM) begin
                        y_out   <= y_sat_s;
                        y_valid <= 1'b1;
                        mult_en <= 1'b0;
                        x2_r    <= x1_r;
                        x1_r    <= x_r;
                        y2_r    <= y1_r;
                        y1_r    <= y_sat_s;
                        state_r <= ST_DONE;
                    end else begin
                        y_valid <= 1'b0;
                    end
                end
                ST_DONE: begin
                    y_valid  <= 1'b0;
                    in_ready <= 1'b1;
                    state_r  <= ST_IDLE;
                end
                default: begin
                    y_valid   <= 1'b0;
                    mult_en   <= 1'b0;
                    mult_a    <= 9'd0;
                    mult_b    <= 13'd0;
                    iss_vld_r <= 1'b0;
                    in_ready  <= 1'b1;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_biquad_mac_seq.sv
// Directed-vector bench for biquad_mac_seq with a behavioural 5-stage multiplier pipeline.
module tb_biquad_mac_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [13:0] x_in;
    logic [9:0]  coef_b0, coef_b1, coef_b2, coef_a1, coef_a2;
    logic        mult_en;
    logic [8:0]  mult_a;
    logic [12:0] mult_b;
    logic [21:0] mult_p;
    logic [13:0] y_out;
    logic        y_valid;

    logic [21:0] p_pipe [0:4];

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] yv_mask, en_mask, rdy_mask;
    int          last_y, first_a, first_b, yv_cnt;

    biquad_mac_seq dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in),
        .coef_b0(coef_b0), .coef_b1(coef_b1), .coef_b2(coef_b2),
        .coef_a1(coef_a1), .coef_a2(coef_a2),
        .mult_en(mult_en), .mult_a(mult_a), .mult_b(mult_b), .mult_p(mult_p),
        .y_out(y_out), .y_valid(y_valid)
    );

    always #5 clk = ~clk;

    // Multiplier model: product of cycle-n operands appears in cycle n+5.
    always @(posedge clk) begin
        p_pipe[0] <= 22'(mult_a) * 22'(mult_b);
        for (int i = 1; i < 5; i++) p_pipe[i] <= p_pipe[i-1];
    end
    assign mult_p = p_pipe[4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_coefs(input int b0, input int b1, input int b2, input int a1, input int a2);
        coef_b0 = 10'(b0); coef_b1 = 10'(b1); coef_b2 = 10'(b2);
        coef_a1 = 10'(a1); coef_a2 = 10'(a2);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Offers one sample in cycle 0 and observes cycles 1..12; with hold, in_valid stays high with junk data.
    task automatic send_sample(input int x, input bit hold);
        int n;
        n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_val("in_ready_wait", int'(in_ready), 1);
        in_valid = 1'b1;
        x_in     = 14'(x);
        yv_mask  = 16'd0;
        en_mask  = 16'd0;
        rdy_mask = 16'd0;
        last_y   = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            in_valid = hold && (c < 12);
            if (hold) x_in = 14'd5555;
            if (y_valid) begin
                yv_mask[c] = 1'b1;
                last_y = $signed(y_out);
            end
            if (mult_en) en_mask[c] = 1'b1;
            if (in_ready) rdy_mask[c] = 1'b1;
            if (c == 1) begin
                first_a = int'(mult_a);
                first_b = int'(mult_b);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic run_check(input string tag, input int x, input int y_exp, input bit hold);
        send_sample(x, hold);
        check_val({tag, "_y"}, last_y, y_exp);
        check_val({tag, "_yv"}, int'(yv_mask), 32'h0000_0800);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b1;
        x_in     = 14'd1000;
        set_coefs(0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        check_val("rst_in_ready", int'(in_ready), 1);
        check_val("rst_mult_en", int'(mult_en), 0);
        check_val("rst_mult_a", int'(mult_a), 0);
        check_val("rst_y_out", int'(y_out), 0);
        check_val("rst_y_valid", int'(y_valid), 0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);

        run_check("zero", 1234, 0, 1'b0);

        // Impulse and latency profile.
        set_coefs(256, 0, 0, 0, 0);
        run_check("imp1", 1000, 1000, 1'b0);
        check_val("imp_en_mask", int'(en_mask), 32'h0000_07FE);
        check_val("imp_rdy_mask", int'(rdy_mask), 32'h0000_1000);
        check_val("imp_first_a", first_a, 256);
        check_val("imp_first_b", first_b, 1000);
        run_check("imp2", 0, 0, 1'b0);

        // Delay tap through x1.
        do_reset();
        set_coefs(0, 128, 0, 0, 0);
        run_check("tap1", 1000, 0, 1'b0);
        run_check("tap2", 0, 500, 1'b0);

        // Feedback through y1 with in_valid held during busy.
        do_reset();
        set_coefs(256, 0, 0, -128, 0);
        run_check("fb1", 1000, 1000, 1'b1);
        check_val("fb_rdy_mask", int'(rdy_mask), 32'h0000_1000);
        run_check("fb2", 0, 500, 1'b1);
        run_check("fb3", 0, 250, 1'b1);

        // Saturation and magnitude clamps.
        do_reset();
        set_coefs(511, 0, 0, 0, 0);
        run_check("sat_pos", 8191, 8191, 1'b0);
        run_check("sat_neg", -8192, -8192, 1'b0);
        check_val("sat_neg_mag_b", first_b, 8191);
        set_coefs(-512, 0, 0, 0, 0);
        run_check("coef_min", 100, -200, 1'b0);
        check_val("coef_min_mag_a", first_a, 511);

        // Mid-operation reset: build history, abort a sample, confirm history cleared.
        do_reset();
        set_coefs(256, 0, 0, 0, 0);
        run_check("pre_abort", 1000, 1000, 1'b0);
        in_valid = 1'b1;
        x_in     = 14'd500;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("abort_mult_en", int'(mult_en), 0);
        check_val("abort_in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst_n  = 1'b1;
        yv_cnt = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (y_valid) yv_cnt++;
        end
        check_val("abort_no_yv", yv_cnt, 0);
        set_coefs(0, 256, 0, -256, 0);
        run_check("hist_clear", 0, 0, 1'b0);
        set_coefs(256, 0, 0, 0, 0);
        run_check("post_imp1", 1000, 1000, 1'b0);
        run_check("post_imp2", 0, 0, 1'b0);

        // Floor versus round-half-up.
        do_reset();
        set_coefs(128, 0, 0, 0, 0);
`ifdef BIQUAD_ROUND_EN
        run_check("rnd_pos", 3, 2, 1'b0);
        run_check("rnd_neg", -3, -1, 1'b0);
`else
        run_check("rnd_pos", 3, 1, 1'b0);
        run_check("rnd_neg", -3, -2, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
